seq_burst_arbiter: RTL and testbench

Shares one sequence_generator instance between NUM_REQ requesters. Each requester asks for a burst of N words. The block arbitrates round-robin and drives the generator's enable one word per accepted beat. It forwards the generator data onto a valid/ready output stream tagged with the requester ID and a last flag. It sits directly in front of sequence_generator, which it owns; the generator's reset_n and clk are shared with this block.

---
 rtl/seq_arb_pkg.sv | 32 +++
 rtl/seq_rr_picker.sv | 50 +++++
 rtl/seq_burst_arbiter.sv | 149 ++++++++++++++
 tb/tb_seq_burst_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_arb_pkg
// Description : Shared definitions for seq_burst_arbiter. Holds the FSM state
//               encoding and the default parameter values. It also holds the
//               8-word cycle produced by sequence_generator, which
//               reference/bench code can use.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_arb_pkg;

    localparam int C_NUM_REQ = 4;
    localparam int C_LEN_W   = 4;
    localparam int C_ID_W    = 2;
    localparam int C_SEQ_LEN = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Word cycle of sequence_generator starting from its reset value.
    localparam logic [7:0] C_SEQ_WORDS [C_SEQ_LEN] = '{
        8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
    };

    function automatic logic [7:0] seq_word(input int unsigned pos);
        return C_SEQ_WORDS[pos % C_SEQ_LEN];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : seq_rr_picker
// Description : Combinational round-robin picker. It searches the request
//               vector starting one position above the last granted index
//               and wraps around. The last granted requester itself has the
//               lowest priority.
// Ports       : i_req     - request vector
//               i_last    - index of last granted requester
//               o_onehot  - one-hot pick (all zero when no request)
//               o_idx     - binary index of the pick
//               o_valid   - at least one request is pending
// Revision    : 1.0 - initial release
// ============================================================================
module seq_rr_picker
    import seq_arb_pkg::*;
#(
    parameter int NUM_REQ = C_NUM_REQ,
    parameter int ID_W    = C_ID_W
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_valid
);

    int w_cand;

    // The loop walks from the furthest offset down to the nearest one. A
    // nearer hit therefore overwrites a farther hit, and the first set bit
    // after i_last wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_cand   = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            w_cand = (int'(i_last) + off) % NUM_REQ;
            if (i_req[w_cand]) begin
                o_onehot         = '0;
                o_onehot[w_cand] = 1'b1;
                o_idx            = ID_W'(w_cand);
            end
        end
    end

    assign o_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/seq_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : seq_burst_arbiter
// Description : Round-robin burst arbiter in front of a shared
//               sequence_generator. A granted requester receives a burst of
//               len words (len==0 means 2**LEN_W words) on a valid/ready
//               stream. The generator advances once for each accepted beat.
// Ports       : clk, reset_n       - clock, async active-low reset
//               req, req_len       - per-requester request and packed length
//               gnt                - one-cycle one-hot grant pulse
//               busy               - burst in progress
//               gen_enable,gen_data- generator advance strobe / data
//               out_valid/ready    - output handshake
//               out_data/id/last   - beat payload, requester id, final beat
//               out_parity         - XOR of out_data (SEQ_ARB_PARITY_EN only)
// Options     : SEQ_ARB_PARITY_EN  - adds the out_parity output
// Revision    : 1.0 - initial release
// ============================================================================
module seq_burst_arbiter
    import seq_arb_pkg::*;
#(
    parameter int NUM_REQ = C_NUM_REQ,
    parameter int LEN_W   = C_LEN_W,
    parameter int ID_W    = C_ID_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic                     gen_enable,
    input  logic [7:0]               gen_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic [ID_W-1:0]          out_id,
`ifdef SEQ_ARB_PARITY_EN
    output logic                     out_parity,
`endif
    output logic                     out_last
);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [ID_W-1:0]    r_last;
    logic [ID_W-1:0]    r_id;
    logic [LEN_W-1:0]   r_lenm1;
    logic [LEN_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_gnt;

    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [ID_W-1:0]    w_pick_idx;
    logic               w_pick_valid;
    logic [LEN_W-1:0]   w_len_sel;
    logic               w_start;
    logic               w_accept;

    seq_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .i_req    (req),
        .i_last   (r_last),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    // Length field of the picked requester. The pick is one-hot, so at most
    // one slice is selected.
    always_comb begin
        w_len_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_onehot[i]) begin
                w_len_sel = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        busy        = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = (r_cnt == r_lenm1);
                if (out_ready && out_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept   = out_valid & out_ready;
    assign gen_enable = w_accept;
    assign out_data   = gen_data;
    assign out_id     = r_id;
    assign gnt        = r_gnt;

`ifdef SEQ_ARB_PARITY_EN
    assign out_parity = out_valid & (^gen_data);
`endif

    // The length is stored as len-1. A len of 0 wraps to all ones, which
    // gives the 2**LEN_W word burst without needing an extra counter bit.
    // After reset, r_last points at the top requester, so requester 0 is
    // searched first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last  <= ID_W'(NUM_REQ - 1);
            r_id    <= '0;
            r_lenm1 <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
        end else begin
            r_gnt <= w_start ? w_pick_onehot : '0;
            if (w_start) begin
                r_id    <= w_pick_idx;
                r_last  <= w_pick_idx;
                r_lenm1 <= w_len_sel - LEN_W'(1);
                r_cnt   <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_burst_arbiter
// Description : Self-checking bench for seq_burst_arbiter. It includes a
//               stand-in sequence_generator and a scoreboard of expected
//               beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_burst_arbiter;
    import seq_arb_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] id;
        logic       last;
    } beat_t;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [15:0] req_len;
    logic [3:0]  gnt;
    logic        busy;
    logic        gen_enable;
    logic [7:0]  gen_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_last;
`ifdef SEQ_ARB_PARITY_EN
    logic        out_parity;
`endif

    int    checks   = 0;
    int    failures = 0;
    int    exp_ptr  = 0;
    beat_t sb_q[$];

    seq_burst_arbiter #(.NUM_REQ(4), .LEN_W(4), .ID_W(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_len    (req_len),
        .gnt        (gnt),
        .busy       (busy),
        .gen_enable (gen_enable),
        .gen_data   (gen_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
`ifdef SEQ_ARB_PARITY_EN
        .out_parity (out_parity),
`endif
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in sequence_generator: resets with reset_n and steps on enable.
    logic [2:0] r_gen_pos;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_gen_pos <= 3'd0;
        else if (gen_enable) r_gen_pos <= r_gen_pos + 3'd1;
    end
    assign gen_data = C_SEQ_WORDS[r_gen_pos];

    // Scoreboard: an accepted beat pops the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            beat_t e;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected got data=%h id=%0d last=%0b, required none",
                         out_data, out_id, out_last);
            end else begin
                e = sb_q.pop_front();
                if ({out_data, out_id, out_last} !== {e.d, e.id, e.last}) begin
                    failures++;
                    $display("FAIL beat got data=%h id=%0d last=%0b, required data=%h id=%0d last=%0b",
                             out_data, out_id, out_last, e.d, e.id, e.last);
                end
`ifdef SEQ_ARB_PARITY_EN
                checks++;
                if (out_parity !== (^e.d)) begin
                    failures++;
                    $display("FAIL parity got %0b, required %0b for data %h",
                             out_parity, ^e.d, e.d);
                end
`endif
            end
        end
    end

    task automatic push_burst(input int id, input int len);
        int n;
        beat_t b;
        n = (len == 0) ? 16 : len;
        for (int k = 0; k < n; k++) begin
            b.d    = C_SEQ_WORDS[exp_ptr % 8];
            b.id   = 2'(id);
            b.last = (k == n - 1);
            sb_q.push_back(b);
            exp_ptr++;
        end
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            if (sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; req = '0; req_len = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (gnt !== 4'b0)       begin failures++; $display("FAIL reset_gnt got %b, required 0000", gnt); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got %b, required 0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b, required 0", out_valid); end
        checks++; if (out_last !== 1'b0)  begin failures++; $display("FAIL reset_last got %b, required 0", out_last); end
        checks++; if (out_id !== 2'd0)    begin failures++; $display("FAIL reset_id got %0d, required 0", out_id); end
        checks++; if (gen_enable !== 1'b0) begin failures++; $display("FAIL reset_gen_en got %b, required 0", gen_enable); end
        reset_n = 1'b1;
    endtask

    task automatic test_single;
        bit ok;
        @(posedge clk); #1;
        req = 4'b0001; req_len = 16'h0003;
        push_burst(0, 3);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got %b, required 0001", gnt); end
        checks++; if (busy !== 1'b1)   begin failures++; $display("FAIL single_busy got %b, required 1", busy); end
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_gnt_pulse got %b, required 0000", gnt); end
        wait_drain(40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_drain got timeout, required all beats"); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_drop got %b, required 0", busy); end
    endtask

    task automatic test_continue;
        bit ok;
        @(posedge clk); #1;
        req = 4'b0100; req_len = 16'h0200;
        push_burst(2, 2);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL cont_gnt got %b, required 0100", gnt); end
        wait_drain(40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL cont_drain got timeout, required all beats"); end
    endtask

    task automatic test_round_robin;
        int  g_id[4];
        int  g_cyc[4];
        int  exp_order[4];
        int  n;
        bit  ok;
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
        n = 0;
        @(posedge clk); #1;
        req = 4'b0011; req_len = 16'h0011;
        push_burst(0, 1); push_burst(1, 1); push_burst(0, 1); push_burst(1, 1);
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (gnt != 4'b0) begin
                g_id[n] = 0;
                for (int b = 0; b < 4; b++) if (gnt[b]) g_id[n] = b;
                g_cyc[n] = c;
                n++;
                if (n == 4) req = '0;
            end
        end
        req = '0;
        checks++;
        if (n != 4) begin
            failures++; $display("FAIL rr_grants got %0d grants, required 4", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (g_id[i] != exp_order[i]) begin
                    failures++; $display("FAIL rr_order[%0d] got %0d, required %0d", i, g_id[i], exp_order[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (g_cyc[i] - g_cyc[i-1] != 2) begin
                        failures++; $display("FAIL rr_gap[%0d] got %0d cycles, required 2", i, g_cyc[i] - g_cyc[i-1]);
                    end
                end
            end
        end
        wait_drain(40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rr_drain got timeout, required all beats"); end
    endtask

    task automatic test_stall;
        bit ok;
        logic [7:0] held;
        @(posedge clk); #1;
        req = 4'b0010; req_len = 16'h0040;
        push_burst(1, 4);
        @(posedge clk); #1;
        req = '0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        held = sb_q[0].d;
        repeat (3) begin
            @(negedge clk);
            checks++; if (out_data !== held) begin failures++; $display("FAIL stall_data got %h, required %h", out_data, held); end
            checks++; if (gen_enable !== 1'b0) begin failures++; $display("FAIL stall_gen_en got %b, required 0", gen_enable); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got %b, required 1", out_valid); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_drain(40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_drain got timeout, required all beats"); end
    endtask

    task automatic test_len_zero;
        bit ok;
        @(posedge clk); #1;
        req = 4'b1000; req_len = 16'h0000;
        push_burst(3, 0);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL len0_gnt got %b, required 1000", gnt); end
        wait_drain(64, ok);
        checks++; if (!ok) begin failures++; $display("FAIL len0_drain got timeout, required 16 beats"); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        @(posedge clk); #1;
        req = 4'b0100; req_len = 16'h0800;
        push_burst(2, 8);
        @(posedge clk); #1;
        req = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got %b, required 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rst_mid_busy got %b, required 0", busy); end
        checks++; if (gnt !== 4'b0)       begin failures++; $display("FAIL rst_mid_gnt got %b, required 0000", gnt); end
        sb_q.delete();
        exp_ptr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        req = 4'b0101; req_len = 16'h0101;
        push_burst(0, 1);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rst_mid_prio got %b, required 0001", gnt); end
        checks++; if (out_data !== 8'hAF) begin failures++; $display("FAIL rst_mid_first got %h, required af", out_data); end
        wait_drain(40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_mid_drain got timeout, required all beats"); end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_continue();
        test_round_robin();
        test_stall();
        test_len_zero();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
